decode_stage: RTL
=================

# decode_stage

Instruction decode and operand-fetch stage feeding the ALU. Accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake, decodes it into the 3-bit ALU operation, and reads the 32x32 register file. It selects the immediate or rs2 as the second operand and registers `alu_op`, `arg1`, `arg2` and `rd` into a single output pipeline slot consumed by the ALU stage. It also owns the register-file write port used by writeback, and halts permanently on an illegal instruction.

## Interface
- `WORD_SIZE`, 32: datapath width; only 32 is supported.
- `REG_COUNT`, 32: register-file depth; x0 is hard-wired to zero.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  `in_instr` holds a valid instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  RV32I instruction word.
- `out_valid`  out  1  output slot holds a decoded operation.
- `out_ready`  in  1  ALU stage consumes the slot this cycle.
- `alu_op`  out  3  0=and, 1=or, 2=xor, 3=sll, 4=srl, 5=add, 6=sub.
- `arg1`  out  WORD_SIZE  rs1 value.
- `arg2`  out  WORD_SIZE  rs2 value or sign-extended I-immediate.
- `rd`  out  5  destination register index.
- `wb_en`  in  1  register-file write enable.
- `wb_rd`  in  5  write index.
- `wb_data`  in  WORD_SIZE  write data.
- `halted`  out  1  sticky illegal-instruction flag.

## Operation
- States:
  - RUN: normal operation.
  - HALT: entered when an illegal instruction is accepted; left only by `rst`.
- Ready rule: `in_ready = (state==RUN) && (!out_valid || out_ready)`. The input is accepted on a cycle where `in_valid && in_ready`.
- Legal R-type instructions (opcode 0110011, funct7=0000000 unless noted):
  - funct3 000 -> add; 000 with funct7 0100000 -> sub.
  - funct3 111 -> and; 110 -> or; 100 -> xor.
  - funct3 001 -> sll; 101 -> srl.
- Legal I-type instructions (opcode 0010011):
  - addi, andi, ori, xori: same funct3 encodings as R-type.
  - slli, srli: require imm[11:5]=0000000; `arg2` = zero-extended shamt `instr[24:20]`.
  - For all other I-type instructions, `arg2` = `{{20{instr[31]}}, instr[31:20]}`.
- Illegal: any other opcode/funct combination (including sra, slt, loads and branches).
  - On accept: state goes to HALT and `halted` is set.
  - The output slot is not loaded and `out_valid` is unchanged.
- Reads of x0 return 0. Writes with `wb_rd==0` are ignored.
- The writeback port is independent of the handshake: a write is accepted every cycle with `wb_en=1`, including in HALT.
- Output hold: while `out_valid && !out_ready`, all outputs stay stable.
- On accept with `out_ready=0` and `out_valid=0`, the slot loads and `out_valid` becomes 1.
- When the slot is consumed (`out_ready=1`) with no new accept, `out_valid` becomes 0.

## Timing
- Latency: one cycle. An instruction accepted at edge N appears on the outputs after edge N.
- Throughput: one instruction per cycle while `out_ready=1`. `in_ready` depends combinationally on `out_ready`.
- Reset values:
  - Outputs: `out_valid=0`, `alu_op=0`, `arg1=0`, `arg2=0`, `rd=0`, `halted=0`, state RUN.
  - All register-file entries are cleared to 0 in the reset cycle.
- `rst` mid-operation discards the output slot and clears HALT. Writeback on a reset cycle is ignored.
- Simultaneous accept and consume: the slot is replaced and `out_valid` stays 1.
- Write and read of the same register in the same cycle: governed by the Configuration section.

## Configuration
- `DECODE_WB_BYPASS_EN` defined: if `wb_en && wb_rd!=0 && wb_rd==rs`, the operand read in the accept cycle returns `wb_data`.
- Not defined: the read returns the pre-write register value. The write lands at the same edge.

## Test plan
- Reset clears state: x5=0x1234 written, then `rst` -> `out_valid=0`, `halted=0`, and a subsequent `add x1,x5,x0` gives `arg1=0`.
- Write then decode: write x3=7 and x4=0xFFFFFFFE, then `sub x9,x3,x4` -> `alu_op=6`, `arg1=7`, `arg2=0xFFFFFFFE`, `rd=9`, one cycle after accept.
- Immediate decode:
  - `addi x2,x0,-1` -> `alu_op=5`, `arg2=0xFFFFFFFF`.
  - `slli x2,x1,31` -> `alu_op=3`, `arg2=31`.
- Backpressure: hold `out_ready=0` for 3 cycles with `in_valid=1` -> `in_ready=0` and outputs stable. Release -> back-to-back instructions each drain in one cycle.
- Illegal instruction: accept `sra` (0x4020D0B3) -> `halted=1`, `in_ready=0` until `rst`, and `out_valid` is not set by it.
- Same-cycle write/read: `wb_en=1`, `wb_rd=6`, `wb_data=0xA5`, while accepting `or x1,x6,x0` with old x6=0 -> `arg1=0xA5` with `DECODE_WB_BYPASS_EN`, `arg1=0` without.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: one instruction per cycle in, one decoded ALU slot out.
// Optional macro DECODE_WB_BYPASS_EN forwards a same-cycle writeback to the operand read.
module decode_stage #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           alu_op,
  output logic [WORD_SIZE-1:0] arg1,
  output logic [WORD_SIZE-1:0] arg2,
  output logic [4:0]           rd,
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 halted
);

  typedef enum logic {ST_RUN, ST_HALT} state_e;
  typedef enum logic [2:0] {
    OP_AND = 3'd0, OP_OR = 3'd1, OP_XOR = 3'd2, OP_SLL = 3'd3,
    OP_SRL = 3'd4, OP_ADD = 3'd5, OP_SUB = 3'd6
  } alu_op_e;

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  alu_op_e                alu_op_q, alu_op_d;
  logic [WORD_SIZE-1:0]   arg1_q, arg1_d, arg2_q, arg2_d;
  logic [4:0]             rd_q, rd_d;
  logic [WORD_SIZE-1:0]   rf_q [REG_COUNT];

  logic [6:0]             opcode, funct7;
  logic [2:0]             funct3;
  logic [4:0]             rs1, rs2, rd_idx;
  logic                   legal, use_imm, accept;
  alu_op_e                dec_op;
  logic [WORD_SIZE-1:0]   imm, rs1_val, rs2_val;

  assign opcode = in_instr[6:0];
  assign rd_idx = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    dec_op  = OP_ADD;
    imm     = {{(WORD_SIZE-12){in_instr[31]}}, in_instr[31:20]};
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b111:  dec_op = OP_AND;
            3'b110:  dec_op = OP_OR;
            3'b100:  dec_op = OP_XOR;
            3'b001:  dec_op = OP_SLL;
            3'b101:  dec_op = OP_SRL;
            default: legal  = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          legal  = 1'b1;
          dec_op = OP_SUB;
        end
      end
      7'b0010011: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        case (funct3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b100:  dec_op = OP_XOR;
          3'b001, 3'b101: begin
            // Shift-immediates: upper imm bits must be zero (srai is rejected).
            dec_op = (funct3 == 3'b001) ? OP_SLL : OP_SRL;
            legal  = (funct7 == 7'b0000000);
            imm    = {{(WORD_SIZE-5){1'b0}}, in_instr[24:20]};
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    rs1_val = (rs1 == 5'd0) ? '0 : rf_q[rs1];
    rs2_val = (rs2 == 5'd0) ? '0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs1) rs1_val = wb_data;
    if (wb_en && wb_rd != 5'd0 && wb_rd == rs2) rs2_val = wb_data;
`endif
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    rd_d        = rd_q;
    if (accept && !legal) state_d = ST_HALT;
    if (accept && legal) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_op;
      arg1_d      = rs1_val;
      arg2_d      = use_imm ? imm : rs2_val;
      rd_d        = rd_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state is assigned only with non-blocking <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      alu_op_q    <= OP_AND;
      arg1_q      <= '0;
      arg2_q      <= '0;
      rd_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      arg1_q      <= arg1_d;
      arg2_q      <= arg2_d;
      rd_q        <= rd_d;
    end
  end

  // NOTE: the register file is built from flops, so clearing it on reset is legal; a RAM macro could not be reset this way.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_en && wb_rd != 5'd0) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign arg1      = arg1_q;
  assign arg2      = arg2_q;
  assign rd        = rd_q;
  assign halted    = (state_q == ST_HALT);

endmodule
